// File: rtl/cycle_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer.
// Issues one-cycle datapath strobes and memory handshakes per step.
module cycle_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        run,
    input  logic [2:0]  opType,
    input  logic        memReadFlag,
    input  logic        memWriteFlag,
    input  logic        regWriteFlag,
    input  logic        zeroFlag,
    input  logic        imemReady,
    input  logic        dmemReady,
    output logic        imemReq,
    output logic        irWriteEnable,
    output logic        aluEnable,
    output logic        dmemReq,
    output logic        dmemWrite,
    output logic        regFileWriteEnable,
    output logic        pcWriteEnable,
    output logic        pcSelBranch,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  faultCode,
    output logic [31:0] retiredCount,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        FAULT     = 3'd7
    } seqState_t;

    localparam logic [2:0] OP_D  = 3'd2;
    localparam logic [2:0] OP_B  = 3'd3;
    localparam logic [2:0] OP_CB = 3'd4;
    localparam logic [2:0] OP_IW = 3'd5;
    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    seqState_t  curState;
    logic [2:0] opReg;
    logic [7:0] waitCnt;
    logic       retire;

    assign state  = curState;
    assign busy   = (curState != IDLE) && (curState != FAULT);
    assign fault  = (curState == FAULT);
    // Every retire is marked by exactly one PC write.
    assign retire = pcWriteEnable;

    always_comb begin
        imemReq            = 1'b0;
        irWriteEnable      = 1'b0;
        aluEnable          = 1'b0;
        dmemReq            = 1'b0;
        dmemWrite          = 1'b0;
        regFileWriteEnable = 1'b0;
        pcWriteEnable      = 1'b0;
        pcSelBranch        = 1'b0;
        case (curState)
            FETCH: begin
                imemReq       = 1'b1;
                irWriteEnable = imemReady;
            end
            DECODE: begin
                pcWriteEnable = (opType == OP_B);
                pcSelBranch   = (opType == OP_B);
            end
            EXECUTE: begin
                aluEnable     = 1'b1;
                pcWriteEnable = (opReg == OP_CB);
                pcSelBranch   = (opReg == OP_CB) && zeroFlag;
            end
            MEMORY: begin
                dmemReq       = 1'b1;
                dmemWrite     = memWriteFlag;
                pcWriteEnable = dmemReady && !memReadFlag;
            end
            WRITEBACK: begin
                regFileWriteEnable = regWriteFlag;
                pcWriteEnable      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            curState     <= IDLE;
            opReg        <= 3'd0;
            waitCnt      <= 8'd0;
            faultCode    <= 2'd0;
            retiredCount <= 32'd0;
        end else begin
            case (curState)
                IDLE: begin
                    if (run) begin
                        curState <= FETCH;
                        waitCnt  <= 8'd0;
                    end
                end
                FETCH: begin
                    if (imemReady) begin
                        curState <= DECODE;
                    end else if (waitCnt == TIMEOUT) begin
                        curState  <= FAULT;
                        faultCode <= 2'd2;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                DECODE: begin
                    opReg <= opType;
                    if (opType > OP_IW) begin
                        curState  <= FAULT;
                        faultCode <= 2'd1;
                    end else if (opType != OP_B) begin
                        curState <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    if (opReg == OP_D) begin
                        curState <= MEMORY;
                        waitCnt  <= 8'd0;
                    end else if (opReg != OP_CB) begin
                        curState <= WRITEBACK;
                    end
                end
                MEMORY: begin
                    if (dmemReady) begin
                        if (memReadFlag) curState <= WRITEBACK;
                    end else if (waitCnt == TIMEOUT) begin
                        curState  <= FAULT;
                        faultCode <= 2'd3;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                WRITEBACK: ;
                FAULT: ;
                default: curState <= FAULT;
            endcase
            // Retire overrides the per-state next-state choice.
            if (retire) begin
                retiredCount <= retiredCount + 32'd1;
                curState     <= run ? FETCH : IDLE;
                waitCnt      <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Randomized bench for cycle_sequencer against a per-instruction
// cycle plan built from the step/latency rules.
module tb_cycle_sequencer;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        resetN, run;
    logic [2:0]  opType;
    logic        memReadFlag, memWriteFlag, regWriteFlag, zeroFlag;
    logic        imemReady, dmemReady;
    logic        imemReq, irWriteEnable, aluEnable, dmemReq, dmemWrite;
    logic        regFileWriteEnable, pcWriteEnable, pcSelBranch;
    logic        busy, fault;
    logic [1:0]  faultCode;
    logic [31:0] retiredCount;
    logic [2:0]  state;

    always #5 clk = ~clk;

    cycle_sequencer #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .resetN(resetN), .run(run), .opType(opType),
        .memReadFlag(memReadFlag), .memWriteFlag(memWriteFlag),
        .regWriteFlag(regWriteFlag), .zeroFlag(zeroFlag),
        .imemReady(imemReady), .dmemReady(dmemReady),
        .imemReq(imemReq), .irWriteEnable(irWriteEnable),
        .aluEnable(aluEnable), .dmemReq(dmemReq), .dmemWrite(dmemWrite),
        .regFileWriteEnable(regFileWriteEnable),
        .pcWriteEnable(pcWriteEnable), .pcSelBranch(pcSelBranch),
        .busy(busy), .fault(fault), .faultCode(faultCode),
        .retiredCount(retiredCount), .state(state)
    );

    typedef struct {
        logic        rstN, run;
        logic [2:0]  op;
        logic        mr, mw, rw, zf, ir, dr;
        logic        chk;
        logic [14:0] exp;
        logic [31:0] cnt;
    } cyc_t;

    cyc_t        plan[$];
    logic [31:0] expCount;
    int          checks = 0;
    int          errors = 0;

    logic [2:0]  iOp;
    logic        iMr, iMw, iRw, iZf;

    task automatic checkEq(input string tag, input int cyc,
                           input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", tag, cyc, obs, exp);
        end
    endtask

    // Cycle record with random don't-care inputs.
    function automatic cyc_t mk(input logic [2:0] st,
                                input logic imq, irw, alu, dmq, dmw,
                                input logic rfw, pcw, pcs,
                                input logic [1:0] code);
        cyc_t c;
        c.rstN = 1'b1;
        c.run  = 1'($urandom);
        c.op   = 3'($urandom);
        c.mr   = 1'($urandom);
        c.mw   = 1'($urandom);
        c.rw   = 1'($urandom);
        c.zf   = 1'($urandom);
        c.ir   = 1'($urandom);
        c.dr   = 1'($urandom);
        c.chk  = 1'b1;
        c.exp  = {st, imq, irw, alu, dmq, dmw, rfw, pcw, pcs & pcw,
                  (st != 3'd0) && (st != 3'd7), st == 3'd7, code};
        c.cnt  = expCount;
        return c;
    endfunction

    function automatic cyc_t withIns(input cyc_t c);
        cyc_t r = c;
        r.op = iOp; r.mr = iMr; r.mw = iMw; r.rw = iRw; r.zf = iZf;
        return r;
    endfunction

    task automatic emitIdle(input int gap);
        cyc_t c;
        for (int i = 0; i < gap; i++) begin
            c = mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
            c.run = 1'b0;
            plan.push_back(c);
        end
        c = mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        c.run = 1'b1;
        plan.push_back(c);
    endtask

    task automatic afterRetire(input bit runAfter, input int gap);
        expCount++;
        if (!runAfter) emitIdle(gap);
    endtask

    // Fault is sticky; reset on the last fault cycle, then restart.
    task automatic emitFault(input logic [1:0] code);
        cyc_t c;
        for (int i = 0; i < 4; i++) begin
            c = mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, code);
            if (i == 3) c.rstN = 1'b0;
            plan.push_back(c);
        end
        expCount = 0;
        emitIdle(0);
    endtask

    task automatic genInstr(input logic [2:0] op, input bit ld,
                            input bit rw, input bit zf,
                            input int latI, input int latD,
                            input bit runAfter, input int gap,
                            input int abortMem);
        cyc_t c;
        int   n;
        bit   rdy;
        iOp = op; iRw = rw; iZf = zf;
        iMr = (op == 3'd2) && ld;
        iMw = (op == 3'd2) && !ld;
        n = (latI > TMO) ? TMO : latI;
        for (int i = 0; i <= n; i++) begin
            rdy = (i == latI);
            c = mk(3'd1, 1, rdy, 0, 0, 0, 0, 0, 0, 2'd0);
            c.ir = rdy;
            plan.push_back(c);
        end
        if (latI > TMO) begin emitFault(2'd2); return; end
        if (op > 3'd5) begin
            plan.push_back(withIns(mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0)));
            emitFault(2'd1);
            return;
        end
        if (op == 3'd3) begin
            c = withIns(mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 1, 2'd0));
            c.run = runAfter;
            plan.push_back(c);
            afterRetire(runAfter, gap);
            return;
        end
        plan.push_back(withIns(mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0)));
        if (op == 3'd4) begin
            c = withIns(mk(3'd3, 0, 0, 1, 0, 0, 0, 1, zf, 2'd0));
            c.run = runAfter;
            plan.push_back(c);
            afterRetire(runAfter, gap);
            return;
        end
        plan.push_back(withIns(mk(3'd3, 0, 0, 1, 0, 0, 0, 0, 0, 2'd0)));
        if (op == 3'd2) begin
            n = (latD > TMO) ? TMO : latD;
            for (int j = 0; j <= n; j++) begin
                rdy = (j == latD);
                c = withIns(mk(3'd4, 0, 0, 0, 1, iMw, 0, rdy && !ld, 0, 2'd0));
                c.dr = rdy;
                if (j == abortMem) begin
                    c.rstN = 1'b0;
                    plan.push_back(c);
                    expCount = 0;
                    emitIdle(1);
                    return;
                end
                if (rdy && !ld) c.run = runAfter;
                plan.push_back(c);
            end
            if (latD > TMO) begin emitFault(2'd3); return; end
            if (!ld) begin afterRetire(runAfter, gap); return; end
        end
        c = withIns(mk(3'd5, 0, 0, 0, 0, 0, rw, 1, 0, 2'd0));
        c.run = runAfter;
        plan.push_back(c);
        afterRetire(runAfter, gap);
    endtask

    initial begin
        cyc_t c;
        logic [14:0] obs;
        resetN = 1'b0; run = 1'b0; opType = 3'd0;
        memReadFlag = 1'b0; memWriteFlag = 1'b0; regWriteFlag = 1'b0;
        zeroFlag = 1'b0; imemReady = 1'b0; dmemReady = 1'b0;
        expCount = 0;

        for (int i = 0; i < 2; i++) begin
            c = mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
            c.rstN = 1'b0;
            c.chk  = 1'b0;
            plan.push_back(c);
        end
        emitIdle(1);
        //        op    ld rw zf latI latD run gap abort
        genInstr(3'd0, 0, 1, 0, 0,  0,   1,  0, -1);
        genInstr(3'd2, 1, 1, 0, 0,  3,   1,  0, -1);
        genInstr(3'd2, 0, 0, 0, 0,  0,   1,  0, -1);
        genInstr(3'd4, 0, 0, 1, 0,  0,   1,  0, -1);
        genInstr(3'd4, 0, 0, 0, 0,  0,   1,  0, -1);
        genInstr(3'd3, 0, 0, 0, 0,  0,   1,  0, -1);
        genInstr(3'd2, 1, 1, 0, 15, 0,   0,  2, -1);
        genInstr(3'd2, 0, 0, 0, 0,  15,  1,  0, -1);
        genInstr(3'd2, 1, 1, 1, 1,  2,   0,  1, -1);
        for (int k = 0; k < 40; k++) begin
            genInstr(3'($urandom_range(0, 5)), 1'($urandom), 1'($urandom),
                     1'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 4), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 2), -1);
        end
        genInstr(3'd6, 0, 0, 0, 0,  0,   1,  0, -1);
        genInstr(3'd1, 0, 1, 0, 16, 0,   1,  0, -1);
        genInstr(3'd0, 0, 1, 0, 0,  0,   1,  0, -1);
        genInstr(3'd2, 1, 1, 0, 0,  16,  1,  0, -1);
        genInstr(3'd2, 1, 1, 0, 0,  5,   1,  0, 1);
        genInstr(3'd7, 0, 0, 0, 2,  0,   1,  0, -1);
        genInstr(3'd5, 0, 1, 0, 0,  0,   0,  1, -1);

        for (int i = 0; i < plan.size(); i++) begin
            c = plan[i];
            @(negedge clk);
            resetN       = c.rstN;
            run          = c.run;
            opType       = c.op;
            memReadFlag  = c.mr;
            memWriteFlag = c.mw;
            regWriteFlag = c.rw;
            zeroFlag     = c.zf;
            imemReady    = c.ir;
            dmemReady    = c.dr;
            #1;
            if (c.chk) begin
                obs = {state, imemReq, irWriteEnable, aluEnable, dmemReq,
                       dmemWrite, regFileWriteEnable, pcWriteEnable,
                       pcSelBranch & pcWriteEnable, busy, fault, faultCode};
                checkEq("outputs", i, 32'(obs), 32'(c.exp));
                checkEq("retiredCount", i, retiredCount, c.cnt);
            end
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
